dtree_feature_sequencer: RTL and testbench
==========================================

// Module: dtree_feature_sequencer
// PURPOSE
//  Front/back end for the combinational decision-tree classifier. Accepts a
//  byte-serial feature frame (valid/ready), assembles it into the flat feature
//  bus driving the tree, waits SETTLE cycles for the tree to resolve, then
//  captures the class code and offers it downstream on a valid/ready port.
//  Sits between the sensor/ADC byte stream and the system result consumer.
// PARAMETERS
//  N_FEAT   5  features per frame (tree inputs X13,X27,X235,X264,X278 order)
//  FEAT_W   8  bits per feature
//  CLASS_W  8  width of class code from tree
//  SETTLE   1  cycles between feat_flat update and class capture (>=1)
// PORTS
//  clk        in   1                 clock, all logic rising-edge
//  rst        in   1                 async reset, active-high
//  s_valid    in   1                 input byte valid
//  s_ready    out  1                 input byte accepted when s_valid&s_ready
//  s_data     in   FEAT_W            feature byte
//  s_last     in   1                 marks final byte of frame
//  feat_flat  out  N_FEAT*FEAT_W     to tree; feature i at [i*FEAT_W +: FEAT_W]
//  class_in   in   CLASS_W           class code returned by tree (combinational)
//  m_valid    out  1                 class result valid
//  m_ready    in   1                 downstream accepts result
//  m_class    out  CLASS_W           captured class code
//  err_frame  out  1                 1-cycle pulse: malformed frame dropped
// BEHAVIOUR
//  - Reset: state=LOAD, idx=0, s_ready=1 after reset release, m_valid=0,
//    m_class=0, feat_flat=0, err_frame=0. Reset mid-frame discards all state.
//  - FSM LOAD: s_ready=1. Each accepted byte written to feature[idx] (first
//    byte -> index 0), idx++. feat_flat only updates from shadow regs on frame
//    completion, so the tree never sees a partial frame.
//    * byte idx==N_FEAT-1 with s_last=1: copy shadow->feat_flat, idx=0, ->EVAL.
//    * s_last=1 with idx<N_FEAT-1 (short frame): drop, err_frame=1, idx=0, stay.
//    * byte idx==N_FEAT-1 with s_last=0 (long frame): drop, err_frame=1,
//      enter SKIP.
//  - SKIP: s_ready=1, discard bytes until one with s_last=1 accepted -> LOAD.
//  - EVAL: s_ready=0; counter runs SETTLE cycles; on expiry m_class<=class_in,
//    m_valid<=1, ->HOLD. Latency last-byte-accept -> m_valid = SETTLE+1 cycles.
//  - HOLD: s_ready=0; m_valid, m_class stable until m_valid&m_ready; on
//    handshake m_valid<=0, ->LOAD (s_ready=1 next cycle). m_ready ignored
//    while m_valid=0.
//  - feat_flat holds last complete frame until next frame completes.
//  - err_frame and a frame completion never coincide; err is combinationally
//    independent of m_* ports.
// CONFIGURATION
//  DTREE_SEQ_STATS_EN defined: adds ports frame_cnt[15:0], err_cnt[15:0]
//   (outputs, reset 0). frame_cnt +1 per m_valid&m_ready handshake,
//   err_cnt +1 per err_frame pulse; both saturate at 16'hFFFF, no wrap.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING (bench drives class_in from golden tree model)
//  1 Frame 00,00,00,00,00(last), m_ready=1 -> m_valid 2 cycles after last,
//    m_class=167, feat_flat=0, s_ready back to 1 the cycle after handshake.
//  2 Frame 00,00,00,00,60(last) -> m_class=17; feat_flat[39:32]=8'h60.
//  3 Short frame 11,22(last) -> err_frame single pulse, no m_valid; following
//    good frame classifies correctly with idx restarted at 0.
//  4 Long frame of 7 bytes, last on byte 7 -> err_frame on byte 5, bytes 6-7
//    swallowed, no m_valid; next frame OK.
//  5 m_ready=0 for 10 cycles after result -> m_valid/m_class stable, s_ready=0,
//    s_valid bytes not accepted; release -> one handshake only.
//  6 Assert rst during byte 3 and again in HOLD -> all outputs at reset values
//    immediately; with STATS_EN, 70000 errors -> err_cnt=16'hFFFF.

Source files
------------

// File: rtl/dtree_feature_sequencer.sv
// dtree_feature_sequencer
//   Byte-serial front end and result back end for the combinational
//   decision-tree classifier. It collects N_FEAT feature bytes into shadow
//   registers and publishes them on feat_flat only when a well-formed frame
//   completes. After SETTLE cycles it captures the tree's class code and
//   offers it on a valid/ready result port. Malformed frames are dropped,
//   and each drop raises err_frame for one cycle.
//   Optional build macro: DTREE_SEQ_STATS_EN adds saturating frame_cnt and
//   err_cnt outputs.
module dtree_feature_sequencer #(
  parameter int N_FEAT  = 5,
  parameter int FEAT_W  = 8,
  parameter int CLASS_W = 8,
  parameter int SETTLE  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [FEAT_W-1:0]        s_data,
  input  logic                     s_last,
  output logic [N_FEAT*FEAT_W-1:0] feat_flat,
  input  logic [CLASS_W-1:0]       class_in,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CLASS_W-1:0]       m_class,
  output logic                     err_frame
`ifdef DTREE_SEQ_STATS_EN
  ,
  output logic [15:0]              frame_cnt,
  output logic [15:0]              err_cnt
`endif
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_SKIP = 2'd1;
  localparam logic [1:0] ST_EVAL = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_FEAT - 1);
  localparam logic [CNT_W-1:0] CNT_EXPIRE = CNT_W'(SETTLE - 1);

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [FEAT_W-1:0] shadow [N_FEAT-1];
  logic              accept;

  // Bytes are taken only while collecting or discarding a frame.
  assign s_ready = (state == ST_LOAD) || (state == ST_SKIP);
  assign accept  = s_valid && s_ready;

  // Shadow registers hold the leading bytes of the frame in progress.
  // NOTE: shadow is deliberately not reset; every entry is rewritten before a
  // frame can complete, so its reset value is never visible.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && accept && idx != IDX_LAST)
      shadow[idx] <= s_data;
  end

  // Frame sequencing FSM: collect, publish, settle, capture, hand off.
  // NOTE: all state here uses non-blocking assignments so that every branch
  // sees the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_LOAD;
      idx       <= '0;
      cnt       <= '0;
      m_valid   <= 1'b0;
      m_class   <= '0;
      feat_flat <= '0;
      err_frame <= 1'b0;
    end else begin
      err_frame <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (idx == IDX_LAST) begin
              idx <= '0;
              if (s_last) begin
                for (int i = 0; i < N_FEAT - 1; i++)
                  feat_flat[i*FEAT_W +: FEAT_W] <= shadow[i];
                feat_flat[(N_FEAT-1)*FEAT_W +: FEAT_W] <= s_data;
                cnt   <= '0;
                state <= ST_EVAL;
              end else begin
                // Long frame: the remaining bytes are consumed in SKIP.
                err_frame <= 1'b1;
                state     <= ST_SKIP;
              end
            end else if (s_last) begin
              // Short frame: drop it and restart at feature 0.
              err_frame <= 1'b1;
              idx       <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_SKIP: begin
          if (accept && s_last)
            state <= ST_LOAD;
        end
        ST_EVAL: begin
          if (cnt == CNT_EXPIRE) begin
            m_class <= class_in;
            m_valid <= 1'b1;
            state   <= ST_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

`ifdef DTREE_SEQ_STATS_EN
  // Saturating counters for completed handshakes and dropped frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (m_valid && m_ready && frame_cnt != 16'hFFFF)
        frame_cnt <= frame_cnt + 16'd1;
      if (err_frame && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dtree_feature_sequencer.sv
// tb_dtree_feature_sequencer
//   Self-checking bench. A golden tree model drives class_in from feat_flat.
//   Expected results are queued as frames are sent and are compared when the
//   result handshake occurs.
module tb_dtree_feature_sequencer;

  localparam int N_FEAT  = 5;
  localparam int FEAT_W  = 8;
  localparam int CLASS_W = 8;
  localparam int SETTLE  = 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     s_valid;
  logic                     s_ready;
  logic [FEAT_W-1:0]        s_data;
  logic                     s_last;
  logic [N_FEAT*FEAT_W-1:0] feat_flat;
  logic [CLASS_W-1:0]       class_in;
  logic                     m_valid;
  logic                     m_ready;
  logic [CLASS_W-1:0]       m_class;
  logic                     err_frame;
`ifdef DTREE_SEQ_STATS_EN
  logic [15:0]              frame_cnt;
  logic [15:0]              err_cnt;
`endif

  dtree_feature_sequencer #(
    .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .feat_flat(feat_flat), .class_in(class_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
    .err_frame(err_frame)
`ifdef DTREE_SEQ_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Golden tree over (X13, X27, X235, X264, X278) = features 0..4.
  function automatic logic [7:0] tree_model(input logic [39:0] f);
    logic [7:0] x13, x235, x264, x278;
    x13  = f[7:0];
    x235 = f[23:16];
    x264 = f[31:24];
    x278 = f[39:32];
    if (x278 < 8'h30) return (x13 < 8'h80) ? 8'd167 : 8'd42;
    if (x235 < 8'h10) return 8'd17;
    return (x264 < 8'h40) ? 8'd99 : 8'd5;
  endfunction

  assign class_in = tree_model(feat_flat);

  typedef struct {
    logic [7:0]  cls;
    logic [39:0] flat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n_hs   = 0;
  int   n_err  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Result monitor: it samples on the falling edge, ahead of the handshake edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_frame) n_err++;
      if (m_valid && m_ready) begin
        n_hs++;
        check("result_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("m_class", m_class, mon_e.cls);
          check("feat_flat", feat_flat, mon_e.flat);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last);
    int w;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    w = 0;
    while (!s_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("s_ready_wait", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // A frame of exactly N_FEAT bytes is well-formed, so it queues its expected result.
  task automatic send_frame(input logic [7:0] b[8], input int n);
    logic [39:0] flat;
    flat = '0;
    for (int i = 0; i < n; i++) begin
      if (i < N_FEAT) flat[i*8 +: 8] = b[i];
      if (i == n - 1 && n == N_FEAT) sb.push_back('{tree_model(flat), flat});
      send_byte(b[i], i == n - 1);
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((sb.size() != 0 || m_valid) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check("idle_wait", w < 200, 1);
  endtask

  task automatic wait_valid();
    int w;
    w = 0;
    while (!m_valid && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("m_valid_wait", m_valid, 1);
  endtask

  initial begin
    logic [7:0] fr[8];
    int lat, e0, h0;
    logic [7:0] held;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_class", m_class, 0);
    check("rst_feat_flat", feat_flat, 0);
    check("rst_err", err_frame, 0);

    // 1: all-zero frame, latency and ready return.
    fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0};
    send_frame(fr, 5);
    lat = 0;
    while (!m_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t1_latency", lat, SETTLE);
    check("t1_class", m_class, 167);
    check("t1_flat", feat_flat, 0);
    check("t1_s_ready_busy", s_ready, 0);
    @(posedge clk); #1;
    check("t1_valid_drop", m_valid, 0);
    check("t1_s_ready_back", s_ready, 1);

    // 2: X278 = 0x60.
    fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h60, 0, 0, 0};
    send_frame(fr, 5);
    wait_idle();
    check("t2_class", m_class, 17);
    check("t2_x278", feat_flat[39:32], 8'h60);

    // 3: short frame, then a good frame.
    e0 = n_err; h0 = n_hs;
    fr = '{8'h11, 8'h22, 0, 0, 0, 0, 0, 0};
    send_frame(fr, 2);
    repeat (4) @(posedge clk); #1;
    check("t3_err_pulses", n_err - e0, 1);
    check("t3_no_result", n_hs - h0, 0);
    check("t3_flat_kept", feat_flat[39:32], 8'h60);
    fr = '{8'h90, 8'h12, 8'h34, 8'h56, 8'h20, 0, 0, 0};
    send_frame(fr, 5);
    wait_idle();
    check("t3_class", m_class, 42);

    // 4: seven-byte frame; the error fires on byte 5.
    e0 = n_err; h0 = n_hs;
    for (int i = 1; i <= 5; i++) send_byte(8'(8'hA0 + i), 1'b0);
    check("t4_err_on_byte5", err_frame, 1);
    send_byte(8'hA6, 1'b0);
    send_byte(8'hA7, 1'b1);
    repeat (4) @(posedge clk); #1;
    check("t4_err_pulses", n_err - e0, 1);
    check("t4_no_result", n_hs - h0, 0);
    check("t4_flat_kept", feat_flat, 40'h2056341290);
    fr = '{8'h01, 8'h02, 8'h20, 8'h50, 8'h70, 0, 0, 0};
    send_frame(fr, 5);
    wait_idle();
    check("t4_class", m_class, 5);

    // 5: downstream back-pressure.
    m_ready = 1'b0;
    fr = '{8'h05, 8'h06, 8'h40, 8'h10, 8'h33, 0, 0, 0};
    send_frame(fr, 5);
    wait_valid();
    held = m_class;
    check("t5_class", held, 99);
    e0 = n_err; h0 = n_hs;
    s_valid = 1'b1; s_data = 8'hFF; s_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t5_valid_hold", m_valid, 1);
      check("t5_class_hold", m_class, 99);
      check("t5_s_ready_low", s_ready, 0);
    end
    s_valid = 1'b0; s_last = 1'b0;
    m_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("t5_one_handshake", n_hs - h0, 1);
    check("t5_no_byte_taken", n_err - e0, 0);

    // 6a: reset while byte 3 is presented.
    send_byte(8'h81, 1'b0);
    send_byte(8'h82, 1'b0);
    s_valid = 1'b1; s_data = 8'h83;
    #2 rst = 1'b1;
    #1;
    check("t6a_m_valid", m_valid, 0);
    check("t6a_m_class", m_class, 0);
    check("t6a_flat", feat_flat, 0);
    check("t6a_err", err_frame, 0);
    s_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    fr = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h10, 0, 0, 0};
    send_frame(fr, 5);
    wait_idle();
    check("t6a_class", m_class, 42);

    // 6b: reset while a result is held.
    m_ready = 1'b0;
    fr = '{8'h00, 8'h00, 8'h05, 8'h00, 8'h40, 0, 0, 0};
    send_frame(fr, 5);
    wait_valid();
    #2 rst = 1'b1;
    #1;
    check("t6b_m_valid", m_valid, 0);
    check("t6b_m_class", m_class, 0);
    check("t6b_flat", feat_flat, 0);
    check("t6b_s_ready", s_ready, 1);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("t6b_no_stale_result", m_valid, 0);
    fr = '{8'h00, 8'h00, 8'h20, 8'h20, 8'h40, 0, 0, 0};
    send_frame(fr, 5);
    wait_idle();
    check("t6b_class", m_class, 99);

`ifdef DTREE_SEQ_STATS_EN
    // Saturation: a one-byte short frame every cycle.
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    s_valid = 1'b1; s_data = 8'h00; s_last = 1'b1;
    repeat (70000) @(posedge clk);
    #1 s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("stats_err_sat", err_cnt, 16'hFFFF);
    check("stats_frame_zero", frame_cnt, 0);
`endif

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
